erbium_result_framer: RTL

Output framing stage directly downstream of the Erbium engine wrapper's result port and upstream of the host results AXI4-Stream. It forwards engine result beats through a 2-entry skid buffer, generates correct `tkeep`, and counts beats and frames. Optionally, it appends one trailer beat per frame carrying beat count, frame index and status, so the host can validate each result burst without a side channel.

---
 rtl/erbium_pkg.sv | 32 +++
 rtl/erbium_skid_buffer.sv | 69 ++++++
 rtl/erbium_result_framer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/erbium_pkg.sv
// Shared Erbium framer definitions: trailer layout, magic word and framer FSM states.
// Pure declarations; no logic and no flow control of its own.
package erbium_pkg;

  localparam logic [31:0] ERBIUM_TRAILER_MAGIC = 32'hE4B1_0001;

  localparam int TRL_W         = 128;
  localparam int TRL_KEEP_W    = TRL_W / 8;
  localparam int TRL_FIELD_W   = 32;
  localparam int TRL_CNT_LSB   = 0;
  localparam int TRL_IDX_LSB   = 32;
  localparam int TRL_MAGIC_LSB = 64;
  localparam int TRL_SAT_BIT   = 96;

  typedef enum logic {
    PASS    = 1'b0,
    TRAILER = 1'b1
  } framer_state_t;

  function automatic logic [TRL_W-1:0] make_trailer(input logic [31:0] cnt,
                                                    input logic [31:0] idx,
                                                    input logic        sat);
    logic [TRL_W-1:0] t;
    t = '0;
    t[TRL_CNT_LSB   +: TRL_FIELD_W] = cnt;
    t[TRL_IDX_LSB   +: TRL_FIELD_W] = idx;
    t[TRL_MAGIC_LSB +: TRL_FIELD_W] = ERBIUM_TRAILER_MAGIC;
    t[TRL_SAT_BIT]                  = sat;
    return t;
  endfunction

endpackage

// File: rtl/erbium_skid_buffer.sv
// 2-entry skid buffer (main output register plus one skid register).
// Latency 1 cycle; in_rdy is registered, drops when the skid fills or hold_nxt requests a stall.
module erbium_skid_buffer #(
  parameter int W = 8
) (
  input  logic         data_clk,
  input  logic         data_rst_n,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic         hold_nxt,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);

  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic         rdy_q, rdy_d;
  logic         in_hs, out_hs;

  assign in_hs  = in_vld & rdy_q;
  assign out_hs = main_vld_q & out_rdy;

  // rdy_q high implies the skid is empty, so a refill from skid and a new input never collide.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_hs) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_hs) begin
        main_d     = in_dat;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_hs) begin
      skid_d     = in_dat;
      skid_vld_d = 1'b1;
    end
    rdy_d = ~skid_vld_d & ~hold_nxt;
  end

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_rdy  = rdy_q;
  assign out_dat = main_q;
  assign out_vld = main_vld_q;

endmodule

// File: rtl/erbium_result_framer.sv
// Frames Erbium engine results onto the host stream; ERBIUM_FRAMER_TRAILER_EN appends a status trailer per frame.
// Latency 1 cycle; in_ready_o is registered and held low from engine last until the trailer handshakes.
module erbium_result_framer
  import erbium_pkg::*;
#(
  parameter int G_DATA_BUS_WIDTH = 512
) (
  input  logic                          data_clk,
  input  logic                          data_rst_n,
  input  logic                          clear_i,
  input  logic [G_DATA_BUS_WIDTH-1:0]   in_data_i,
  input  logic                          in_valid_i,
  input  logic                          in_last_i,
  output logic                          in_ready_o,
  output logic [G_DATA_BUS_WIDTH-1:0]   out_tdata_o,
  output logic [G_DATA_BUS_WIDTH/8-1:0] out_tkeep_o,
  output logic                          out_tvalid_o,
  output logic                          out_tlast_o,
  input  logic                          out_tready_i,
  output logic                          frame_done_o,
  output logic [31:0]                   frame_count_o
);

  localparam int W  = G_DATA_BUS_WIDTH;
  localparam int KW = W / 8;

  logic [W:0]  skid_dat;
  logic        skid_vld, skid_out_rdy, hold_nxt;
  logic        in_trl, data_hs, frame_end;
  logic [31:0] beat_cnt_q, frame_idx_q;
  logic        sat_q, done_q;

  erbium_skid_buffer #(.W(W + 1)) u_skid (
    .data_clk   (data_clk),
    .data_rst_n (data_rst_n),
    .in_dat     ({in_last_i, in_data_i}),
    .in_vld     (in_valid_i),
    .in_rdy     (in_ready_o),
    .hold_nxt   (hold_nxt),
    .out_dat    (skid_dat),
    .out_vld    (skid_vld),
    .out_rdy    (skid_out_rdy)
  );

  assign skid_out_rdy = out_tready_i & ~in_trl;
  assign data_hs      = skid_vld & skid_out_rdy;

`ifdef ERBIUM_FRAMER_TRAILER_EN
  framer_state_t state_q;
  logic          blk_q, trl_hs;
  logic [W-1:0]  trl_dat;

  assign in_trl    = (state_q == TRAILER);
  assign trl_hs    = in_trl & out_tready_i;
  assign frame_end = trl_hs;
  // Block the engine from its last beat until the trailer leaves, so the skid never mixes frames.
  assign hold_nxt  = (in_valid_i & in_ready_o & in_last_i) | (blk_q & ~trl_hs);

  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      state_q <= PASS;
      blk_q   <= 1'b0;
    end else begin
      blk_q <= hold_nxt;
      case (state_q)
        PASS:    if (data_hs && skid_dat[W]) state_q <= TRAILER;
        TRAILER: if (out_tready_i) state_q <= PASS;
        default: state_q <= PASS;
      endcase
    end
  end

  always_comb begin
    trl_dat            = '0;
    trl_dat[TRL_W-1:0] = make_trailer(beat_cnt_q, frame_idx_q, sat_q);
    out_tkeep_o        = {KW{skid_vld}};
    if (in_trl) begin
      out_tkeep_o                 = '0;
      out_tkeep_o[TRL_KEEP_W-1:0] = '1;
    end
  end

  assign out_tvalid_o = in_trl | skid_vld;
  assign out_tlast_o  = in_trl;
  assign out_tdata_o  = in_trl ? trl_dat : skid_dat[W-1:0];
`else
  assign in_trl       = 1'b0;
  assign hold_nxt     = 1'b0;
  assign frame_end    = data_hs & skid_dat[W];
  assign out_tvalid_o = skid_vld;
  assign out_tlast_o  = skid_vld & skid_dat[W];
  assign out_tdata_o  = skid_dat[W-1:0];
  assign out_tkeep_o  = {KW{skid_vld}};
`endif

  // The saturated flag marks that at least one beat was not counted.
  always_ff @(posedge data_clk or negedge data_rst_n) begin
    if (!data_rst_n) begin
      beat_cnt_q  <= '0;
      sat_q       <= 1'b0;
      frame_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= frame_end;
      if (frame_end) begin
        beat_cnt_q <= '0;
        sat_q      <= 1'b0;
      end else if (data_hs) begin
        if (&beat_cnt_q) sat_q <= 1'b1;
        else             beat_cnt_q <= beat_cnt_q + 32'd1;
      end
      if (clear_i)        frame_idx_q <= '0;
      else if (frame_end) frame_idx_q <= frame_idx_q + 32'd1;
    end
  end

  assign frame_done_o  = done_q;
  assign frame_count_o = frame_idx_q;

endmodule
